// File: rtl/box_area_sequencer.sv
// box_area_sequencer: loads four serial 4-bit box coordinates, fires the box-area datapath
// once per box and returns area then perimeter on a valid/ready stream.
module box_area_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_sel,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] op_count
);
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, SEND_M, SEND_N} state_t;
  localparam logic [8:0] TMO = 9'(TIMEOUT);
  state_t state, nxt;
  logic [3:0] ops [4];
  logic [3:0] m_r, n_r, m_w, n_w;
  logic [1:0] idx;
  logic [7:0] tcnt;
  logic in_acc, out_acc, tmo;
  VectorBoxArea u_dp (.a(ops[0]), .b(ops[1]), .c(ops[2]), .d(ops[3]), .m(m_w), .n(n_w));
  assign in_ready = state == IDLE || state == LOAD;
  assign out_valid = state == SEND_M || state == SEND_N;
  assign out_sel = state == SEND_N;
  assign out_data = state == SEND_M ? m_r : state == SEND_N ? n_r : 4'd0;
  assign busy = state != IDLE;
  assign in_acc = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;
  // an accept in the cycle the count would expire wins over the timeout
  assign tmo = TMO != 9'd0 && state == LOAD && !in_acc && {1'b0, tcnt} + 9'd1 == TMO;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = in_acc ? LOAD : IDLE;
      LOAD:    nxt = tmo ? IDLE : (in_acc && idx == 2'd3) ? EXEC : LOAD;
      EXEC:    nxt = SEND_M;
      SEND_M:  nxt = out_acc ? SEND_N : SEND_M;
      SEND_N:  nxt = out_acc ? IDLE : SEND_N;
      default: nxt = IDLE;
    endcase
    if (clr) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ops <= '{default: '0};
      m_r <= '0;
      n_r <= '0;
      idx <= '0;
      tcnt <= '0;
      timeout_err <= 1'b0;
      op_count <= '0;
    end else begin
      state <= nxt;
      timeout_err <= !clr && tmo;
      if (clr || tmo) begin
        ops <= '{default: '0};
        m_r <= '0;
        n_r <= '0;
        idx <= '0;
        tcnt <= '0;
      end else begin
        if (in_acc) begin
          ops[idx] <= in_data;
          idx <= idx + 2'd1;
          tcnt <= '0;
        end else if (state == LOAD) begin
          tcnt <= tcnt + 8'd1;
        end
        if (state == EXEC) begin
          m_r <= m_w;
          n_r <= n_w;
        end
        if (state == SEND_N && out_acc) op_count <= op_count + 8'd1;
      end
    end
  end
endmodule

// VectorBoxArea: combinational 4-bit box area and perimeter, truncated to 4 bits.
module VectorBoxArea (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  output logic [3:0] m,
  output logic [3:0] n
);
  logic [3:0] dx, dy;
  assign dx = c >= a ? c - a : a - c;
  assign dy = b >= d ? b - d : d - b;
  assign m = dx * dy;
  assign n = {dx[2:0], 1'b0} + {dy[2:0], 1'b0};
endmodule

// File: tb/tb_box_area_sequencer.sv
// tb_box_area_sequencer: directed stimulus against a scoreboard of expected result beats
// derived from box arithmetic, plus hand-computed literal checks.
module tb_box_area_sequencer;
  logic clk = 1'b0;
  logic rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_sel, busy, timeout_err;
  logic [3:0] in_data, out_data;
  logic [7:0] op_count;
  int n_chk = 0;
  int n_fail = 0;
  int mcnt = 0;
  bit armed = 0;
  logic [4:0] q [$];

  box_area_sequencer #(.TIMEOUT(3)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .busy(busy), .timeout_err(timeout_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // offer one beat (called just after a rising edge) and wait until it is taken
  task automatic put(input logic [3:0] v);
    logic r;
    int k;
    in_valid = 1'b1;
    in_data = v;
    k = 0;
    do begin
      @(negedge clk);
      r = in_ready;
      tick();
      k++;
    end while (!r && k < 100);
    if (!r) chk("put_accept", r, 1);
  endtask

  // send a whole box and queue its expected area/perimeter beats
  task automatic send_box(input int a, input int b, input int c, input int d);
    int dx, dy;
    put(4'(a));
    put(4'(b));
    put(4'(c));
    put(4'(d));
    dx = a > c ? a - c : c - a;
    dy = b > d ? b - d : d - b;
    q.push_back({1'b0, 4'((dx * dy) % 16)});
    q.push_back({1'b1, 4'((2 * dx + 2 * dy) % 16)});
  endtask

  task automatic lit_box(input int a, input int b, input int c, input int d, input int em, input int en);
    out_ready = 1'b1;
    send_box(a, b, c, d);
    in_valid = 1'b0;
    @(negedge clk);
    chk("exec_no_valid", out_valid, 0);
    chk("exec_busy", busy, 1);
    @(negedge clk);
    chk("m_valid", out_valid, 1);
    chk("m_data", out_data, em);
    chk("m_sel", out_sel, 0);
    @(negedge clk);
    chk("n_data", out_data, en);
    chk("n_sel", out_sel, 1);
    @(negedge clk);
    chk("ready_again", in_ready, 1);
    chk("idle_again", busy, 0);
    tick();
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || out_valid) && k < 50);
    chk("wait_idle", busy, 0);
    tick();
  endtask

  // scoreboard: every meaningful output cycle must show the head of the expected queue
  always @(negedge clk) begin
    if (armed) begin
      chk("op_count", op_count, mcnt);
      if (out_valid) begin
        chk("in_ready_low_while_out", in_ready, 0);
        chk("pending_beats", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("sb_data", out_data, q[0][3:0]);
          chk("sb_sel", out_sel, q[0][4]);
          if (rst_n && !clr && out_ready) begin
            if (q[0][4]) mcnt = (mcnt + 1) % 256;
            void'(q.pop_front());
          end
        end
      end
      if (!rst_n) begin
        q.delete();
        mcnt = 0;
      end else if (clr) q.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    in_data = 4'd0;
    out_ready = 1'b1;
    tick();
    armed = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_op_count", op_count, 0);
    tick();
    rst_n = 1'b1;
    lit_box(1, 1, 3, 4, 6, 10);
    lit_box(3, 4, 1, 1, 6, 10);
    lit_box(2, 3, 7, 9, 14, 6);
    lit_box(0, 0, 15, 15, 1, 12);
    // backpressure on the area beat
    out_ready = 1'b0;
    send_box(1, 1, 3, 4);
    in_valid = 1'b0;
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!out_valid && k < 10);
      chk("bp_valid", out_valid, 1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_data", out_data, 6);
      chk("bp_hold_sel", out_sel, 0);
      chk("bp_in_ready", in_ready, 0);
      if (i < 4) @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_m", out_data, 6);
    @(negedge clk);
    chk("bp_release_n", out_data, 10);
    chk("bp_release_sel", out_sel, 1);
    tick();
    // back-to-back boxes with in_valid held high
    send_box(2, 3, 7, 9);
    send_box(0, 0, 15, 15);
    in_valid = 1'b0;
    wait_idle();
    chk("b2b_count", op_count, 7);
    // inter-beat timeout after two beats
    put(4'd5);
    put(4'd5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("to_idle1_busy", busy, 1);
    chk("to_idle1_err", timeout_err, 0);
    @(negedge clk);
    @(negedge clk);
    chk("to_idle3_busy", busy, 1);
    chk("to_idle3_err", timeout_err, 0);
    @(negedge clk);
    chk("to_fired_busy", busy, 0);
    chk("to_fired_err", timeout_err, 1);
    chk("to_fired_ready", in_ready, 1);
    @(negedge clk);
    chk("to_pulse_end", timeout_err, 0);
    tick();
    lit_box(0, 0, 2, 2, 4, 8);
    chk("to_count", op_count, 8);
    // abort during the perimeter beat
    out_ready = 1'b0;
    send_box(2, 3, 7, 9);
    in_valid = 1'b0;
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!out_valid && k < 10);
      chk("ab_valid", out_valid, 1);
    end
    tick();
    out_ready = 1'b1;
    tick();
    clr = 1'b1;
    @(negedge clk);
    chk("ab_in_send_n", out_sel, 1);
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("ab_out_valid", out_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_count_kept", op_count, 8);
    tick();
    // reset in the middle of loading
    put(4'd1);
    put(4'd2);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_busy", busy, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_data", out_data, 0);
    chk("mr_out_sel", out_sel, 0);
    chk("mr_timeout_err", timeout_err, 0);
    chk("mr_op_count", op_count, 0);
    tick();
    rst_n = 1'b1;
    lit_box(1, 1, 3, 4, 6, 10);
    @(negedge clk);
    chk("final_count", op_count, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
